// File: rtl/bus_mux_arbiter.sv
// bus_mux_arbiter: two requesters share one registered 2:1 mux output.
// Round-robin arbitration on ties, a single output register with a
// valid/ready handshake, and a 16-bit count of completed handshakes.
module bus_mux_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [15:0]      xfer_cnt
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic state;
  logic last_sel;
  logic space;
  logic grant;

  // The output register can take new data when it is empty or is being drained this cycle.
  assign space = (state == EMPTY) || (out_ready == 1'b1);
  assign grant = gnt0 | gnt1;
  assign out_valid = (state == FULL);

  // Grant decision: a lone request wins outright, a tie goes to the side opposite last_sel.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    sel  = 1'b0;
    if (!rst) begin
      if (space) begin
        if (req0 && req1) begin
          gnt0 = last_sel;
          gnt1 = ~last_sel;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
      if (gnt1)
        sel = 1'b1;
      else if (gnt0)
        sel = 1'b0;
      else
        sel = last_sel;
    end
  end

  // Output register, occupancy state, round-robin pointer and handshake counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      last_sel <= 1'b1;
      xfer_cnt <= 16'd0;
    end else begin
      if ((state == FULL) && out_ready)
        xfer_cnt <= xfer_cnt + 16'd1;
      if (grant) begin
        out_data <= sel ? data1 : data0;
        state    <= FULL;
        last_sel <= sel;
      end else if ((state == FULL) && out_ready) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Testbench for bus_mux_arbiter: directed scenarios plus randomized traffic,
// all checked against a transaction-level reference model.
module tb_bus_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [31:0] data0, data1;
  logic        gnt0, gnt1, sel;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [15:0] xfer_cnt;

  int vectors = 0;
  int errors  = 0;

  // Reference model: what the output register holds, who won last, and the handshake tally.
  logic        m_valid;
  logic [31:0] m_data;
  int          m_last;
  logic [15:0] m_cnt;

  bus_mux_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .data1(data1), .gnt1(gnt1),
    .sel(sel), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, compare every output mid-cycle, then advance the model.
  task automatic step(input logic r, input logic q0, input logic [31:0] d0,
                      input logic q1, input logic [31:0] d1, input logic rdy);
    int   g;
    logic room;
    logic esel;
    rst = r; req0 = q0; data0 = d0; req1 = q1; data1 = d1; out_ready = rdy;
    #4;
    g = -1;
    if (!r) begin
      room = !m_valid || rdy;
      if (room) begin
        if (q0 && q1)  g = 1 - m_last;
        else if (q0)   g = 0;
        else if (q1)   g = 1;
      end
    end
    if (r)           esel = 1'b0;
    else if (g >= 0) esel = (g == 1);
    else             esel = (m_last == 1);
    chk("gnt0", {31'd0, gnt0}, {31'd0, g == 0});
    chk("gnt1", {31'd0, gnt1}, {31'd0, g == 1});
    chk("sel", {31'd0, sel}, {31'd0, esel});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) chk("out_data", out_data, m_data);
    chk("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, m_cnt});
    if (r) begin
      m_valid = 1'b0; m_data = '0; m_last = 1; m_cnt = 16'd0;
    end else begin
      if (m_valid && rdy) m_cnt = m_cnt + 16'd1;
      if (g >= 0) begin
        m_data  = (g == 1) ? d1 : d0;
        m_valid = 1'b1;
        m_last  = g;
      end else if (rdy) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_valid = 1'b0; m_data = '0; m_last = 1; m_cnt = 16'd0;
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_data", out_data, 32'd0);
    chk("reset_cnt", {16'd0, xfer_cnt}, 32'd0);

    // Single requester.
    step(1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_data", out_data, 32'hFFFFFFFF);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("single_cnt", {16'd0, xfer_cnt}, 32'd1);

    // Tie right after reset: requester 0 first, then alternate.
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, 32'h01234567, 1'b1, 32'h89ABCDEF, 1'b1);
    chk("tie_last_data", out_data, 32'h89ABCDEF);

    // Stall with both requests held.
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'hEEEEEEEE, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'h11111111, 1'b1, 32'h22222222, 1'b0);
    chk("stall_data", out_data, 32'hEEEEEEEE);
    chk("stall_cnt", {16'd0, xfer_cnt}, 32'd0);
    step(1'b0, 1'b1, 32'h11111111, 1'b1, 32'h22222222, 1'b1);
    chk("stall_release_data", out_data, 32'h22222222);

    // Reset mid-stream while full, then a tie must go to requester 0.
    step(1'b0, 1'b1, 32'h33333333, 1'b1, 32'h44444444, 1'b0);
    step(1'b1, 1'b1, 32'h55555555, 1'b1, 32'h66666666, 1'b1);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_cnt", {16'd0, xfer_cnt}, 32'd0);
    step(1'b0, 1'b1, 32'hA0A0A0A0, 1'b1, 32'hB0B0B0B0, 1'b1);
    chk("midrst_tie_data", out_data, 32'hA0A0A0A0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0));

    // Counter wrap.
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 65536; i++)
      step(1'b0, 1'b1, i, 1'b0, 32'h0, 1'b1);
    chk("wrap_ffff", {16'd0, xfer_cnt}, 32'h0000FFFF);
    step(1'b0, 1'b1, 32'h12345678, 1'b0, 32'h0, 1'b1);
    chk("wrap_zero", {16'd0, xfer_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
